// File: rtl/reg_status_file_pkg.sv
// Shared constants and small helpers for the register status file.
package reg_status_file_pkg;

  // Architectural register file geometry
  localparam int RSF_REG_NUM    = 32;
  localparam int RSF_REG_IDX_W  = 5;
  localparam int RSF_DATA_W     = 32;

  // ROB id geometry (mirrors `RoB_addr / `RoB_size of the ROB)
  localparam int RSF_ROB_ADDR_W = 4;
  localparam int RSF_ROB_SIZE   = 16;

  // x0 is hardwired to zero: it is never renamed, written or reported busy
  function automatic logic is_x0(input logic [RSF_REG_IDX_W-1:0] idx);
    return (idx == {RSF_REG_IDX_W{1'b0}});
  endfunction

endpackage

// File: rtl/reg_status_file_query_port.sv
// Combinational operand lookup for one decoder source register, including
// the same-cycle commit bypass.
module reg_query_port
  import reg_status_file_pkg::*;
#(
  parameter int REG_NUM    = RSF_REG_NUM,
  parameter int ROB_ADDR_W = RSF_ROB_ADDR_W
) (
  input  logic [RSF_REG_IDX_W-1:0] i_rs,
  input  logic [REG_NUM-1:0]       i_busy,
  input  logic [ROB_ADDR_W-1:0]    i_dep   [REG_NUM],
  input  logic [RSF_DATA_W-1:0]    i_value [REG_NUM],
  input  logic                     i_commit_en,
  input  logic [RSF_REG_IDX_W-1:0] i_commit_rd,
  input  logic [ROB_ADDR_W-1:0]    i_robid,
  input  logic [RSF_DATA_W-1:0]    i_commit_value,
  output logic                     o_busy,
  output logic [ROB_ADDR_W-1:0]    o_dep,
  output logic [RSF_DATA_W-1:0]    o_value
);

  logic                  w_sel_busy;
  logic [ROB_ADDR_W-1:0] w_sel_dep;
  logic [RSF_DATA_W-1:0] w_sel_value;
  logic                  w_bypass;

  // Fetch the entry addressed by the query and decide whether the retiring
  // instruction is exactly the one this register is waiting on.
  always_comb begin
    w_sel_busy  = i_busy[i_rs];
    w_sel_dep   = i_dep[i_rs];
    w_sel_value = i_value[i_rs];
    w_bypass    = i_commit_en
                  && (i_commit_rd == i_rs)
                  && w_sel_busy
                  && (w_sel_dep == i_robid);
  end

  // Resolve the answer: x0 is constant zero, a matching commit forwards its
  // value, a pending rename reports its tag, otherwise the stored value.
  always_comb begin
    o_busy  = 1'b0;
    o_dep   = {ROB_ADDR_W{1'b0}};
    o_value = {RSF_DATA_W{1'b0}};
    if (is_x0(i_rs)) begin
      o_busy  = 1'b0;
      o_dep   = {ROB_ADDR_W{1'b0}};
      o_value = {RSF_DATA_W{1'b0}};
    end else if (w_bypass) begin
      o_busy  = 1'b0;
      o_dep   = {ROB_ADDR_W{1'b0}};
      o_value = i_commit_value;
    end else if (w_sel_busy) begin
      o_busy  = 1'b1;
      o_dep   = w_sel_dep;
      o_value = {RSF_DATA_W{1'b0}};
    end else begin
      o_busy  = 1'b0;
      o_dep   = {ROB_ADDR_W{1'b0}};
      o_value = w_sel_value;
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename tags. Issue records
// the owning ROB entry, commit retires values, clear drops every tag.
module reg_status_file
  import reg_status_file_pkg::*;
#(
  parameter int REG_NUM    = RSF_REG_NUM,
  parameter int ROB_ADDR_W = RSF_ROB_ADDR_W
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic                     rf_issue,
  input  logic [RSF_REG_IDX_W-1:0] rf_issue_rd,
  input  logic [ROB_ADDR_W-1:0]    rf_new_dep,
  input  logic                     rf_commit,
  input  logic [RSF_REG_IDX_W-1:0] rf_commit_rd,
  input  logic [ROB_ADDR_W-1:0]    rf_robid,
  input  logic [RSF_DATA_W-1:0]    rf_value,
  input  logic [RSF_REG_IDX_W-1:0] dc_rs1,
  input  logic [RSF_REG_IDX_W-1:0] dc_rs2,
  output logic                     dc_rs1_busy,
  output logic [ROB_ADDR_W-1:0]    dc_rs1_dep,
  output logic [RSF_DATA_W-1:0]    dc_rs1_value,
  output logic                     dc_rs2_busy,
  output logic [ROB_ADDR_W-1:0]    dc_rs2_dep,
  output logic [RSF_DATA_W-1:0]    dc_rs2_value
);

  // Architectural state
  logic [RSF_DATA_W-1:0] r_value [REG_NUM];
  logic [REG_NUM-1:0]    r_busy;
  logic [ROB_ADDR_W-1:0] r_dep   [REG_NUM];

  // Qualified update strobes
  logic w_flush;
  logic w_commit_en;
  logic w_commit_wr;
  logic w_commit_tag_hit;
  logic w_issue_wr;

  // Qualify requests: clear outranks everything, a stalled core changes
  // nothing, and x0 is never a write target.
  always_comb begin
    w_flush          = rdy_in && clear;
    w_commit_en      = rdy_in && rf_commit && !clear;
    w_commit_wr      = w_commit_en && !is_x0(rf_commit_rd);
    w_commit_tag_hit = r_busy[rf_commit_rd] && (r_dep[rf_commit_rd] == rf_robid);
    w_issue_wr       = rdy_in && rf_issue && !clear && !is_x0(rf_issue_rd);
  end

  // Retired values: commit always lands, whether or not the tag still matches.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_value[i] <= {RSF_DATA_W{1'b0}};
      end
    end else if (w_commit_wr) begin
      r_value[rf_commit_rd] <= rf_value;
    end
  end

  // Rename tags: flush wipes all, a commit releases only its own tag, and a
  // same-cycle issue to the same register overrides the release (later
  // assignment wins) since the issuing instruction is younger.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_busy <= {REG_NUM{1'b0}};
      for (int i = 0; i < REG_NUM; i++) begin
        r_dep[i] <= {ROB_ADDR_W{1'b0}};
      end
    end else if (w_flush) begin
      r_busy <= {REG_NUM{1'b0}};
      for (int i = 0; i < REG_NUM; i++) begin
        r_dep[i] <= {ROB_ADDR_W{1'b0}};
      end
    end else begin
      if (w_commit_wr && w_commit_tag_hit) begin
        r_busy[rf_commit_rd] <= 1'b0;
        r_dep[rf_commit_rd]  <= {ROB_ADDR_W{1'b0}};
      end
      if (w_issue_wr) begin
        r_busy[rf_issue_rd] <= 1'b1;
        r_dep[rf_issue_rd]  <= rf_new_dep;
      end
    end
  end

  // Source operand lookup for rs1
  reg_query_port #(
    .REG_NUM    (REG_NUM),
    .ROB_ADDR_W (ROB_ADDR_W)
  ) u_query_rs1 (
    .i_rs           (dc_rs1),
    .i_busy         (r_busy),
    .i_dep          (r_dep),
    .i_value        (r_value),
    .i_commit_en    (w_commit_en),
    .i_commit_rd    (rf_commit_rd),
    .i_robid        (rf_robid),
    .i_commit_value (rf_value),
    .o_busy         (dc_rs1_busy),
    .o_dep          (dc_rs1_dep),
    .o_value        (dc_rs1_value)
  );

  // Source operand lookup for rs2
  reg_query_port #(
    .REG_NUM    (REG_NUM),
    .ROB_ADDR_W (ROB_ADDR_W)
  ) u_query_rs2 (
    .i_rs           (dc_rs2),
    .i_busy         (r_busy),
    .i_dep          (r_dep),
    .i_value        (r_value),
    .i_commit_en    (w_commit_en),
    .i_commit_rd    (rf_commit_rd),
    .i_robid        (rf_robid),
    .i_commit_value (rf_value),
    .o_busy         (dc_rs2_busy),
    .o_dep          (dc_rs2_dep),
    .o_value        (dc_rs2_value)
  );

endmodule

// File: tb/tb_reg_status_file.sv
// Scoreboard bench for reg_status_file: the driver computes the expected
// query answers from a register/tag model and queues them; the monitor pops
// and compares on every falling edge.
module tb_reg_status_file;

  logic        clk_in = 1'b0;
  logic        rst_n_in, rdy_in, clear;
  logic        rf_issue, rf_commit;
  logic [4:0]  rf_issue_rd, rf_commit_rd, dc_rs1, dc_rs2;
  logic [3:0]  rf_new_dep, rf_robid, dc_rs1_dep, dc_rs2_dep;
  logic [31:0] rf_value, dc_rs1_value, dc_rs2_value;
  logic        dc_rs1_busy, dc_rs2_busy;

  typedef struct packed {
    logic        b1;
    logic [3:0]  d1;
    logic [31:0] v1;
    logic        b2;
    logic [3:0]  d2;
    logic [31:0] v2;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  // Reference state: what each architectural register holds and who owns it
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [3:0]  m_dep  [32];

  reg_status_file dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rdy_in       (rdy_in),
    .clear        (clear),
    .rf_issue     (rf_issue),
    .rf_issue_rd  (rf_issue_rd),
    .rf_new_dep   (rf_new_dep),
    .rf_commit    (rf_commit),
    .rf_commit_rd (rf_commit_rd),
    .rf_robid     (rf_robid),
    .rf_value     (rf_value),
    .dc_rs1       (dc_rs1),
    .dc_rs2       (dc_rs2),
    .dc_rs1_busy  (dc_rs1_busy),
    .dc_rs1_dep   (dc_rs1_dep),
    .dc_rs1_value (dc_rs1_value),
    .dc_rs2_busy  (dc_rs2_busy),
    .dc_rs2_dep   (dc_rs2_dep),
    .dc_rs2_value (dc_rs2_value)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i]  = 32'h0;
      m_busy[i] = 1'b0;
      m_dep[i]  = 4'h0;
    end
  endtask

  // Expected answer for one source register given the inputs now on the bus
  task automatic model_query(input logic [4:0] rs, output logic b, output logic [3:0] d,
                             output logic [31:0] v);
    if (rs == 5'd0) begin
      b = 1'b0; d = 4'h0; v = 32'h0;
    end else if (rst_n_in && rdy_in && rf_commit && !clear && rf_commit_rd == rs
                 && m_busy[rs] && m_dep[rs] == rf_robid) begin
      b = 1'b0; d = 4'h0; v = rf_value;
    end else if (m_busy[rs]) begin
      b = 1'b1; d = m_dep[rs]; v = 32'h0;
    end else begin
      b = 1'b0; d = 4'h0; v = m_val[rs];
    end
  endtask

  // Drive one cycle of stimulus, queue the expected query answer, then
  // advance the model to the state after the coming rising edge.
  task automatic step(input bit rst, input bit rdy, input bit clr,
                      input bit iss, input logic [4:0] ird, input logic [3:0] nd,
                      input bit com, input logic [4:0] crd, input logic [3:0] rid,
                      input logic [31:0] val, input logic [4:0] q1, input logic [4:0] q2);
    exp_t        e;
    logic        b;
    logic [3:0]  d;
    logic [31:0] v;
    @(posedge clk_in);
    #2;
    rst_n_in = rst; rdy_in = rdy; clear = clr;
    rf_issue = iss; rf_issue_rd = ird; rf_new_dep = nd;
    rf_commit = com; rf_commit_rd = crd; rf_robid = rid; rf_value = val;
    dc_rs1 = q1; dc_rs2 = q2;
    if (!rst) model_reset();
    model_query(q1, b, d, v);
    e.b1 = b; e.d1 = d; e.v1 = v;
    model_query(q2, b, d, v);
    e.b2 = b; e.d2 = d; e.v2 = v;
    sb_q.push_back(e);
    if (rst && rdy) begin
      if (clr) begin
        for (int i = 0; i < 32; i++) begin
          m_busy[i] = 1'b0;
          m_dep[i]  = 4'h0;
        end
      end else begin
        if (com && crd != 5'd0) begin
          m_val[crd] = val;
          if (m_busy[crd] && m_dep[crd] == rid) begin
            m_busy[crd] = 1'b0;
            m_dep[crd]  = 4'h0;
          end
        end
        if (iss && ird != 5'd0) begin
          m_busy[ird] = 1'b1;
          m_dep[ird]  = nd;
        end
      end
    end
  endtask

  task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
    step(1, 1, 0, 0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 32'h0, q1, q2);
  endtask

  task automatic do_issue(input logic [4:0] rd, input logic [3:0] nd,
                          input logic [4:0] q1, input logic [4:0] q2);
    step(1, 1, 0, 1, rd, nd, 0, 5'd0, 4'd0, 32'h0, q1, q2);
  endtask

  task automatic do_commit(input logic [4:0] rd, input logic [3:0] rid, input logic [31:0] val,
                           input logic [4:0] q1, input logic [4:0] q2);
    step(1, 1, 0, 0, 5'd0, 4'd0, 1, rd, rid, val, q1, q2);
  endtask

  // Monitor: outputs are combinational, so each driven cycle presents one
  // answer; compare it mid-cycle on the falling edge.
  initial begin
    forever begin
      @(negedge clk_in);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("rs1_busy",  {31'h0, dc_rs1_busy}, {31'h0, mon_e.b1});
        chk("rs1_dep",   {28'h0, dc_rs1_dep},  {28'h0, mon_e.d1});
        chk("rs1_value", dc_rs1_value,         mon_e.v1);
        chk("rs2_busy",  {31'h0, dc_rs2_busy}, {31'h0, mon_e.b2});
        chk("rs2_dep",   {28'h0, dc_rs2_dep},  {28'h0, mon_e.d2});
        chk("rs2_value", dc_rs2_value,         mon_e.v2);
      end
    end
  end

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b0; clear = 1'b0;
    rf_issue = 1'b0; rf_issue_rd = 5'd0; rf_new_dep = 4'd0;
    rf_commit = 1'b0; rf_commit_rd = 5'd0; rf_robid = 4'd0; rf_value = 32'h0;
    dc_rs1 = 5'd0; dc_rs2 = 5'd0;
    model_reset();

    // Reset state, then rename x5 and observe the tag
    step(0, 1, 0, 0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 32'h0, 5'd5, 5'd0);
    do_issue(5'd5, 4'd3, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    // Matching commit: same-cycle bypass, then retired state
    do_commit(5'd5, 4'd3, 32'hDEADBEEF, 5'd5, 5'd1);
    idle(5'd5, 5'd5);
    // Stale commit leaves the younger tag in place
    do_issue(5'd5, 4'd3, 5'd5, 5'd0);
    do_issue(5'd5, 4'd7, 5'd5, 5'd0);
    do_commit(5'd5, 4'd3, 32'h00000011, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    do_commit(5'd5, 4'd7, 32'h00000022, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    // Same-register issue and commit in one cycle
    do_issue(5'd6, 4'd1, 5'd6, 5'd0);
    step(1, 1, 0, 1, 5'd6, 4'd2, 1, 5'd6, 4'd1, 32'hCAFE0006, 5'd6, 5'd6);
    idle(5'd6, 5'd0);
    do_commit(5'd6, 4'd2, 32'hCAFE0066, 5'd6, 5'd0);
    idle(5'd6, 5'd5);
    // Issue and commit to different registers together
    step(1, 1, 0, 1, 5'd10, 4'd9, 1, 5'd11, 4'd0, 32'h0000BBBB, 5'd10, 5'd11);
    idle(5'd10, 5'd11);
    // Flush with a wrong-path issue and commit in the same cycle
    do_commit(5'd4, 4'd0, 32'h44444444, 5'd4, 5'd0);
    do_issue(5'd1, 4'd1, 5'd0, 5'd0);
    do_issue(5'd2, 4'd2, 5'd0, 5'd0);
    do_issue(5'd3, 4'd3, 5'd1, 5'd2);
    step(1, 1, 1, 1, 5'd9, 4'd5, 1, 5'd4, 4'd0, 32'h99999999, 5'd3, 5'd4);
    idle(5'd1, 5'd2);
    idle(5'd3, 5'd9);
    idle(5'd4, 5'd5);
    // x0 writes are discarded
    step(1, 1, 0, 1, 5'd0, 4'd6, 1, 5'd0, 4'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle(5'd0, 5'd6);
    // Stalled issue and stalled commit have no effect; bypass is gated too
    step(1, 0, 0, 1, 5'd7, 4'd4, 0, 5'd0, 4'd0, 32'h0, 5'd7, 5'd0);
    idle(5'd7, 5'd0);
    do_issue(5'd12, 4'd8, 5'd0, 5'd0);
    step(1, 0, 0, 0, 5'd0, 4'd0, 1, 5'd12, 4'd8, 32'h12121212, 5'd12, 5'd7);
    idle(5'd12, 5'd0);
    // Asynchronous reset mid-cycle clears state without a clock edge
    do_issue(5'd8, 4'd6, 5'd0, 5'd0);
    step(0, 1, 0, 0, 5'd0, 4'd0, 0, 5'd0, 4'd0, 32'h0, 5'd8, 5'd5);
    idle(5'd8, 5'd5);

    // Randomized traffic over a small register/tag window to provoke hits
    for (int n = 0; n < 600; n++) begin
      step(1, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 3)),
           32'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk_in);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus per-register rename tags for the Tomasulo core.
- Receiving end of the reorder buffer's issue/commit register-update interface: records the in-flight ROB entry that owns each destination register and retires committed values.
- Answers the decoder's combinational operand queries (rs1/rs2): either a ready value or the ROB id to wait on.
- Drops all rename state on a ROB clear (mispredict flush).

Parameters:
- REG_NUM, 32, number of architectural registers (x0 hardwired zero).
- ROB_ADDR_W, 4, width of a ROB entry id; equals `RoB_addr.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  global enable; when low, no state changes.
- clear  input  1  ROB flush; registered pulse from the ROB.
- rf_issue  input  1  rename-write request for rf_issue_rd.
- rf_issue_rd  input  5  destination register of the issuing instruction.
- rf_new_dep  input  ROB_ADDR_W  ROB id allocated to that instruction.
- rf_commit  input  1  retire request.
- rf_commit_rd  input  5  destination register of the retiring instruction.
- rf_robid  input  ROB_ADDR_W  ROB id of the retiring instruction.
- rf_value  input  32  retired value.
- dc_rs1  input  5  decoder query register 1.
- dc_rs2  input  5  decoder query register 2.
- dc_rs1_busy  output  1  rs1 is waiting on an in-flight ROB entry.
- dc_rs1_dep  output  ROB_ADDR_W  ROB id rs1 depends on; 0 when not busy.
- dc_rs1_value  output  32  rs1 value; valid when not busy, 0 when busy.
- dc_rs2_busy  output  1  same as dc_rs1_busy, for rs2.
- dc_rs2_dep  output  ROB_ADDR_W  same as dc_rs1_dep, for rs2.
- dc_rs2_value  output  32  same as dc_rs1_value, for rs2.

Behaviour:
- State: value[REG_NUM] (32 bit), busy[REG_NUM] (1 bit), dep[REG_NUM] (ROB_ADDR_W bits).
- Reset (rst_n_in low, asynchronous): all value, busy and dep entries are 0.
- Query outputs are purely combinational, so the decoder sees the answer in the same cycle.
- Priority per edge, when rdy_in is high: clear > issue/commit.
- Clear (clear and rdy_in high):
  - All busy and dep entries become 0; values are retained.
  - Any rf_issue or rf_commit in the same cycle is ignored, because it belongs to the wrong path.
- Commit (rf_commit high, clear low, rf_commit_rd != 0):
  - value[rd] <= rf_value unconditionally.
  - If busy[rd] is set and dep[rd] == rf_robid, then busy[rd] <= 0 and dep[rd] <= 0.
  - If a younger instruction has renamed rd, the tag is kept.
- Issue (rf_issue high, clear low, rf_issue_rd != 0): busy[rd] <= 1 and dep[rd] <= rf_new_dep.
- Issue and commit to the same rd in the same cycle: issue wins busy/dep, and the commit still writes value.
- Issue and commit to different registers in the same cycle: both apply.
- x0:
  - Writes to x0 are discarded.
  - A query of x0 returns busy 0, dep 0, value 0.
- Query rule, evaluated independently for rs1 and rs2:
  - Commit bypass: if rf_commit is high, clear is low, rs == rf_commit_rd != 0, busy[rs] is set and dep[rs] == rf_robid, the output is busy 0 and value rf_value.
  - Otherwise, if busy[rs] is set, the output is busy 1, dep dep[rs], value 0.
  - Otherwise the output is busy 0 and value value[rs].
- The query does not forward the same-cycle issue. The instruction being issued reads its sources before its own rename takes effect.
- rdy_in low: nothing is written. Queries still reflect current state, with the bypass gated by rdy_in.
- ROB id wrap-around is handled by the ROB; ids are compared by equality only.

Decomposition:
- Shared const.v/package holds:
  - `RoB_addr / `RoB_size.
  - REG_NUM and the register index width (5).
- Natural sub-module: reg_query_port. It is the combinational bypass/lookup logic, instantiated twice, once for rs1 and once for rs2.
- Sequential state stays in reg_status_file.

Test Plan:
- Reset then query x5: expect busy=0, value=0. Issue rd=5, dep=3; next cycle query x5: expect busy=1, dep=3, value=0.
- With x5 busy on dep 3, commit rd=5, robid=3, value=0xDEADBEEF:
  - Same-cycle query expects busy=0, value=0xDEADBEEF.
  - Next cycle, state shows busy=0, value=0xDEADBEEF.
- Stale commit: issue x5 with dep 3, then issue x5 with dep 7, then commit rd=5, robid=3, value=0x11. Expect value[5]=0x11 and busy=1, dep=7. The same-cycle query of x5 does not bypass and expects busy=1, dep=7.
- Same cycle issue rd=6, dep=2 and commit rd=6, robid=1, with x6 on dep 1: expect x6 busy=1, dep=2, value=commit value.
- Three registers busy, then assert clear together with an issue to x9 and a commit to x4:
  - All busy entries become 0.
  - x9 is not busy.
  - x4 keeps its old value.
  - Earlier-committed values are unchanged.
- Writes to x0 via issue and commit, rdy_in=0 stall during an issue, and rst_n_in asserted mid-cycle:
  - x0 always reads 0.
  - The stalled issue has no effect.
  - Asynchronous reset zeroes all state immediately, without a clock edge.
